// File: rtl/fht_pkg.sv
// Shared definitions for the FHT twiddle sequencer and the butterfly datapath:
// sequencer states, derived transform sizes and the ROM pair-select encoding.
package fht_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      LAST
   } state_t;

   // Pair 1 of the ROM holds the angle advanced by pi/2.
   localparam logic SEL_P0 = 1'b0;
   localparam logic SEL_P1 = 1'b1;

   function automatic int stages(input int a_bit);
      return a_bit + 2;
   endfunction

   function automatic int half_n(input int a_bit);
      return 1 << (a_bit + 1);
   endfunction

endpackage

// File: rtl/fht_bfly_cnt.sv
// Stage/butterfly counter pair: cnt walks the butterflies of one stage,
// stg advances on each wrap, and the whole pair returns to zero after the final issue.
module fht_bfly_cnt
   import fht_pkg::*;
#(
   parameter int A_BIT = 10,
   parameter int S_BIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             en,
   output logic [S_BIT-1:0] stg,
   output logic [A_BIT:0]   cnt,
   output logic             cnt_last,
   output logic             terminal
);

   localparam int S = stages(A_BIT);

   // H-1 is all ones in the cnt width.
   assign cnt_last = (cnt == {(A_BIT + 1){1'b1}});
   assign terminal = cnt_last && (stg == S_BIT'(S - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg <= '0;
         cnt <= '0;
      end else if (clear) begin
         stg <= '0;
         cnt <= '0;
      end else if (en) begin
         if (cnt_last) begin
            cnt <= '0;
            stg <= terminal ? '0 : stg + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fht_twiddle_seq.sv
// FHT butterfly/twiddle sequencer: issues one butterfly per cycle, drives the
// twiddle ROM address combinationally and registers the rest to align with ROM data.
module fht_twiddle_seq
   import fht_pkg::*;
#(
   parameter int A_BIT = 10,
   parameter int S_BIT = 4
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic             iSTART,
   input  logic             iHOLD,
   output logic [A_BIT-1:0] oADDR,
   output logic             oSEL,
   output logic [A_BIT+1:0] oIDX_A,
   output logic [A_BIT+1:0] oIDX_B,
   output logic [S_BIT-1:0] oSTAGE,
   output logic             oVALID,
   output logic             oSTAGE_LAST,
   output logic             oBUSY,
   output logic             oDONE
);

   localparam int S = stages(A_BIT);

   state_t           state;
   state_t           state_nxt;
   logic             start_ok;
   logic             issue;
   logic [S_BIT-1:0] stg;
   logic [A_BIT:0]   cnt;
   logic             cnt_last;
   logic             terminal;

   logic [A_BIT:0]   j;
   logic [A_BIT:0]   g;
   logic [A_BIT:0]   k;
   logic [S_BIT-1:0] kshift;
   logic [A_BIT+1:0] idx_a;
   logic [A_BIT+1:0] idx_b;

   fht_bfly_cnt #(
      .A_BIT(A_BIT),
      .S_BIT(S_BIT)
   ) u_cnt (
      .clk     (iCLK),
      .rst_n   (iRESET),
      .clear   (start_ok),
      .en      (issue),
      .stg     (stg),
      .cnt     (cnt),
      .cnt_last(cnt_last),
      .terminal(terminal)
   );

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (iSTART) begin
               start_ok  = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (!iHOLD) begin
               issue = 1'b1;
               if (terminal) state_nxt = LAST;
            end
         end
         LAST:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Butterfly span is 2^stg; the twiddle index k is j scaled up so that
   // every stage addresses the same N/2-entry angle space.
   always_comb begin
      j      = cnt & ~({(A_BIT + 1){1'b1}} << stg);
      g      = cnt >> stg;
      kshift = S_BIT'(S - 1) - stg;
      k      = j << kshift;
      idx_a  = ({1'b0, g} << ({1'b0, stg} + 1'b1)) | {1'b0, j};
      idx_b  = idx_a + ((A_BIT + 2)'(1) << stg);
   end

   assign oADDR = (state == RUN) ? k[A_BIT-1:0] : '0;
   assign oBUSY = (state != IDLE);
   assign oDONE = (state == LAST);

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         oSEL        <= SEL_P0;
         oIDX_A      <= '0;
         oIDX_B      <= '0;
         oSTAGE      <= '0;
         oVALID      <= 1'b0;
         oSTAGE_LAST <= 1'b0;
      end else if (issue) begin
         oSEL        <= k[A_BIT] ? SEL_P1 : SEL_P0;
         oIDX_A      <= idx_a;
         oIDX_B      <= idx_b;
         oSTAGE      <= stg;
         oVALID      <= 1'b1;
         oSTAGE_LAST <= cnt_last;
      end else begin
         oVALID      <= 1'b0;
         oSTAGE_LAST <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fht_twiddle_seq.sv
// Scoreboard bench for fht_twiddle_seq: a 16-point instance checked butterfly by
// butterfly, plus a default-size instance checked for totals and one far-out butterfly.
module tb_fht_twiddle_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start;
   logic       hold;
   logic [1:0] addr;
   logic       sel;
   logic [3:0] idx_a;
   logic [3:0] idx_b;
   logic [3:0] stage;
   logic       valid;
   logic       stage_last;
   logic       busy;
   logic       done;

   logic        big_start;
   logic        big_hold;
   logic [9:0]  big_addr;
   logic        big_sel;
   logic [11:0] big_idx_a;
   logic [11:0] big_idx_b;
   logic [3:0]  big_stage;
   logic        big_valid;
   logic        big_stage_last;
   logic        big_busy;
   logic        big_done;

   fht_twiddle_seq #(.A_BIT(2), .S_BIT(4)) u_dut (
      .iCLK(clk), .iRESET(rst_n), .iSTART(start), .iHOLD(hold),
      .oADDR(addr), .oSEL(sel), .oIDX_A(idx_a), .oIDX_B(idx_b),
      .oSTAGE(stage), .oVALID(valid), .oSTAGE_LAST(stage_last),
      .oBUSY(busy), .oDONE(done)
   );

   fht_twiddle_seq #(.A_BIT(10), .S_BIT(4)) u_big (
      .iCLK(clk), .iRESET(rst_n), .iSTART(big_start), .iHOLD(big_hold),
      .oADDR(big_addr), .oSEL(big_sel), .oIDX_A(big_idx_a), .oIDX_B(big_idx_b),
      .oSTAGE(big_stage), .oVALID(big_valid), .oSTAGE_LAST(big_stage_last),
      .oBUSY(big_busy), .oDONE(big_done)
   );

   typedef struct packed {
      logic       sel;
      logic [1:0] addr;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] stage;
      logic       last;
      logic       done;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Expected butterflies of one 16-point run, derived from the index definitions.
   task automatic push_run();
      exp_t e;
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 8; c++) begin
            int span = 1 << s;
            int jj = c % span;
            int gg = c / span;
            int kk = jj * (16 / (2 * span));
            e.sel   = (kk >= 4);
            e.addr  = 2'(kk % 4);
            e.a     = 4'(gg * 2 * span + jj);
            e.b     = 4'(gg * 2 * span + jj + span);
            e.stage = 4'(s);
            e.last  = (c == 7);
            e.done  = (s == 3) && (c == 7);
            sbq.push_back(e);
         end
      end
   endtask

   // Hand-computed reference points, by position within a run.
   function automatic bit spot_exp(input int n, output exp_t e);
      spot_exp = 1'b1;
      case (n)
         0:       e = {1'b0, 2'd0, 4'd0, 4'd1,  4'd0, 1'b0, 1'b0};
         7:       e = {1'b0, 2'd0, 4'd14, 4'd15, 4'd0, 1'b1, 1'b0};
         8:       e = {1'b0, 2'd0, 4'd0, 4'd2,  4'd1, 1'b0, 1'b0};
         9:       e = {1'b1, 2'd0, 4'd1, 4'd3,  4'd1, 1'b0, 1'b0};
         19:      e = {1'b1, 2'd2, 4'd3, 4'd7,  4'd2, 1'b0, 1'b0};
         29:      e = {1'b1, 2'd1, 4'd5, 4'd13, 4'd3, 1'b0, 1'b0};
         31:      e = {1'b1, 2'd3, 4'd7, 4'd15, 4'd3, 1'b1, 1'b1};
         default: begin e = '0; spot_exp = 1'b0; end
      endcase
   endfunction

   logic [1:0] addr_prev = '0;
   int         run_valid = 0;
   exp_t       mon_got;
   exp_t       mon_exp;
   exp_t       mon_spot;

   // ROM address leads the registered outputs by one cycle, so pair each
   // valid with the address seen on the previous cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         run_valid = 0;
      end else if (valid) begin
         mon_got = {sel, addr_prev, idx_a, idx_b, stage, stage_last, done};
         if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_valid: got %0h expected none", mon_got);
         end else begin
            mon_exp = sbq.pop_front();
            checkOutput("butterfly", 64'(mon_got), 64'(mon_exp));
         end
         if (spot_exp(run_valid, mon_spot))
            checkOutput("spot", 64'(mon_got), 64'(mon_spot));
         run_valid = done ? 0 : run_valid + 1;
      end else if (busy) begin
         checkOutput("done_without_valid", 64'(done), 64'(0));
      end
      addr_prev = addr;
   end

   logic [9:0] big_addr_prev = '0;
   int         big_n = 0;
   bit         big_spot_seen = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         big_n = 0;
      end else if (big_valid) begin
         if (big_n == 11 * 2048 + 1500) begin
            big_spot_seen = 1'b1;
            checkOutput("big_sel", 64'(big_sel), 64'(1));
            checkOutput("big_addr", 64'(big_addr_prev), 64'(476));
            checkOutput("big_idx_a", 64'(big_idx_a), 64'(1500));
            checkOutput("big_idx_b", 64'(big_idx_b), 64'(3548));
            checkOutput("big_stage", 64'(big_stage), 64'(11));
         end
         if (big_done) checkOutput("big_done_pos", 64'(big_n), 64'(24575));
         big_n++;
      end
      big_addr_prev = big_addr;
   end

   task automatic check_all_zero(input string name);
      checkOutput(name, 64'({addr, sel, idx_a, idx_b, stage, valid, stage_last, busy, done}), 64'(0));
   endtask

   // One full run; optional hold window and an ignored mid-run start pulse.
   task automatic applyStimulus(input int hold_at, input int hold_len, input int hold_addr,
                                input int start_at, input int exp_busy);
      int  busy_cnt = 0;
      bit  seen_end = 1'b0;
      push_run();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         hold  = (cyc >= hold_at) && (cyc < hold_at + hold_len);
         start = (cyc == start_at);
         if (hold) begin
            #1;
            checkOutput("hold_addr", 64'(addr), 64'(hold_addr));
         end
         if (busy) busy_cnt++;
         else begin
            seen_end = 1'b1;
            break;
         end
         @(negedge clk);
      end
      hold  = 1'b0;
      start = 1'b0;
      if (!seen_end) begin
         tests++;
         fails++;
         $display("[TB] FAIL run_timeout: got busy after 200 cycles expected idle");
      end
      checkOutput("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
      checkOutput("sb_drained", 64'(sbq.size()), 64'(0));
   endtask

   initial begin
      int  big_busy_cnt;
      bit  big_end;
      rst_n     = 1'b0;
      start     = 1'b0;
      hold      = 1'b0;
      big_start = 1'b0;
      big_hold  = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("in_reset");
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check_all_zero("idle");
      end

      applyStimulus(-1, 0, 0, -1, 33);
      applyStimulus(19, 3, 2, -1, 36);
      applyStimulus(-1, 0, 0, 10, 33);

      // Abort mid stage 2 with an asynchronous reset, then rerun from scratch.
      push_run();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      #3 rst_n = 1'b0;
      #1 check_all_zero("mid_run_reset");
      sbq.delete();
      repeat (2) @(negedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("after_reset");
      applyStimulus(-1, 0, 0, -1, 33);

      big_busy_cnt = 0;
      big_end      = 1'b0;
      big_start    = 1'b1;
      @(negedge clk);
      big_start = 1'b0;
      for (int cyc = 0; cyc < 30000; cyc++) begin
         if (big_busy) big_busy_cnt++;
         else begin
            big_end = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!big_end) begin
         tests++;
         fails++;
         $display("[TB] FAIL big_timeout: got busy after 30000 cycles expected idle");
      end
      checkOutput("big_valids", 64'(big_n), 64'(24576));
      checkOutput("big_busy_cycles", 64'(big_busy_cnt), 64'(24577));
      checkOutput("big_spot_seen", 64'(big_spot_seen), 64'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
